// File: rtl/irq_pkg.sv
// Shared constants for the parametrised POKEY-style interrupt controller:
// channel indices, default masks and a ceil-log2 helper.
package irq_pkg;

  localparam int IRQ_T1     = 0;
  localparam int IRQ_T2     = 1;
  localparam int IRQ_T4     = 2;
  localparam int IRQ_SDOFIN = 3;
  localparam int IRQ_SDOCMP = 4;
  localparam int IRQ_SDICMP = 5;
  localparam int IRQ_KEY    = 6;
  localparam int IRQ_BRK    = 7;

  localparam logic [7:0] POKEY_LEVEL_MASK  = 8'h08;
  localparam logic [7:0] POKEY_ACTLOW_MASK = 8'h08;
  localparam logic [7:0] POKEY_OVR_MASK    = 8'h60;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/irq_chan.sv
// One interrupt channel: source history, pending latch and sticky overrun.
// Level channels bypass the latch and simply follow the masked source.
module irq_chan (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic is_level_i,
  input  logic is_edge_i,
  input  logic ovr_en_i,
  input  logic act_i,
  input  logic irqen_i,
  input  logic new_en_i,
  input  logic ovr_clr_i,
  output logic pend_o,
  output logic ovrun_o
);

  logic src_q, src_d;
  logic pend_q, pend_d;
  logic ovrun_q, ovrun_d;
  logic trig;
  logic ovr_set;

  always_comb begin
    trig    = is_edge_i ? (act_i & ~src_q) : act_i;
    ovr_set = ovr_en_i & ~is_level_i & pend_q & trig & irqen_i;
    src_d   = src_q;
    pend_d  = pend_q;
    ovrun_d = ovrun_q;
    if (en_i) begin
      src_d = act_i;
      // The enable seen before this cycle gates the trigger; the new enable clears.
      if (is_level_i) pend_d = new_en_i & act_i;
      else            pend_d = new_en_i & (pend_q | (trig & irqen_i));
      ovrun_d = ovr_set | (ovrun_q & ~ovr_clr_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovrun_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      pend_q  <= pend_d;
      ovrun_q <= ovrun_d;
    end
  end

  assign pend_o  = pend_q;
  assign ovrun_o = ovrun_q;

endmodule

// File: rtl/irq_ctrl_param.sv
// Parametrised interrupt controller: IRQEN mask register, per-channel latches,
// IRQ line, active-low IRQST readback and highest-index source ID.
module irq_ctrl_param
  import irq_pkg::*;
#(
  parameter int          NUM_CH       = 8,
  parameter int          ID_W         = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH),
  parameter logic [15:0] LEVEL_MASK   = 16'(POKEY_LEVEL_MASK),
  parameter logic [15:0] ACT_LOW_MASK = 16'(POKEY_ACTLOW_MASK),
  parameter logic [15:0] EDGE_MASK    = 16'h0000,
  parameter logic [15:0] OVR_MASK     = 16'(POKEY_OVR_MASK),
  parameter logic [15:0] RST_EN       = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              wr_en,
  input  logic [NUM_CH-1:0] Dw,
  input  logic              ovr_clr,
  input  logic [NUM_CH-1:0] src,
  output logic              irq,
  output logic [NUM_CH-1:0] Dr,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] ovrun
);

  localparam logic [NUM_CH-1:0] ACT_LOW = ACT_LOW_MASK[NUM_CH-1:0];
  localparam logic [NUM_CH-1:0] EN_RST  = RST_EN[NUM_CH-1:0];

  logic [NUM_CH-1:0] irqen_q, irqen_d;
  logic [NUM_CH-1:0] new_en;
  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] pend;
  logic [ID_W-1:0]   id_d;

  assign act     = src ^ ACT_LOW;
  assign new_en  = wr_en ? Dw : irqen_q;
  assign irqen_d = en ? new_en : irqen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irqen_q <= EN_RST;
    else          irqen_q <= irqen_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    irq_chan u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .en_i       (en),
      .is_level_i (LEVEL_MASK[g]),
      .is_edge_i  (EDGE_MASK[g]),
      .ovr_en_i   (OVR_MASK[g]),
      .act_i      (act[g]),
      .irqen_i    (irqen_q[g]),
      .new_en_i   (new_en[g]),
      .ovr_clr_i  (ovr_clr),
      .pend_o     (pend[g]),
      .ovrun_o    (ovrun[g])
    );
  end

  // Ascending scan so the highest pending index wins.
  always_comb begin
    id_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend[i]) id_d = ID_W'(i);
    end
  end

  assign irq    = |pend;
  assign Dr     = ~pend;
  assign irq_id = id_d;

endmodule

// File: tb/tb_irq_ctrl_param.sv
// Directed bench for irq_ctrl_param: POKEY-default instance plus an
// edge-triggered channel-0 instance, hand-computed expectations.
module tb_irq_ctrl_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, wr_en, ovr_clr;
  logic [7:0] Dw, src;
  logic       irq;
  logic [7:0] Dr, ovrun;
  logic [2:0] irq_id;

  logic       wr_e;
  logic [7:0] dw_e, src_e;
  logic       irq_e;
  logic [7:0] dr_e, ovrun_e;
  logic [2:0] id_e;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  irq_ctrl_param u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .wr_en(wr_en), .Dw(Dw),
    .ovr_clr(ovr_clr), .src(src), .irq(irq), .Dr(Dr), .irq_id(irq_id),
    .ovrun(ovrun)
  );

  irq_ctrl_param #(.EDGE_MASK(16'h0001)) u_edge (
    .clk(clk), .reset_n(reset_n), .en(en), .wr_en(wr_e), .Dw(dw_e),
    .ovr_clr(ovr_clr), .src(src_e), .irq(irq_e), .Dr(dr_e), .irq_id(id_e),
    .ovrun(ovrun_e)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0; wr_en = 1'b0; wr_e = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; Dw = d;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; wr_en = 1'b0; ovr_clr = 1'b0;
    Dw = 8'h00; src = 8'h08;
    wr_e = 1'b0; dw_e = 8'h00; src_e = 8'h08;
    #3;
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_dr", 16'(Dr), 16'h00FF);
    chk("rst_id", 16'(irq_id), 16'h0);
    chk("rst_ovr", 16'(ovrun), 16'h0);
    #10 reset_n = 1'b1;
    tick();
    chk("idle_dr", 16'(Dr), 16'h00FF);

    // single pulse on channel 0
    wr(8'h01);
    src = 8'h09; tick(); src = 8'h08;
    chk("p0_irq", 16'(irq), 16'h1);
    chk("p0_dr", 16'(Dr), 16'h00FE);
    chk("p0_id", 16'(irq_id), 16'h0);
    wr_en = 1'b1; Dw = 8'h00;
    @(posedge clk); #1;
    chk("hold_irq", 16'(irq), 16'h1);
    wr(8'h00);
    chk("clr_irq", 16'(irq), 16'h0);
    chk("clr_dr", 16'(Dr), 16'h00FF);

    // triggers on disabled channels are dropped
    src = 8'hF7; tick();
    chk("dis_irq", 16'(irq), 16'h0);
    chk("dis_dr", 16'(Dr), 16'h00FF);
    src = 8'h08; wr(8'hFF);
    chk("late_en_irq", 16'(irq), 16'h0);
    wr(8'h00);

    // overrun on SDICMP
    wr(8'h20);
    src = 8'h28; tick();
    src = 8'h08; tick(); tick();
    src = 8'h28; tick();
    chk("ovr_dr", 16'(Dr), 16'h00DF);
    chk("ovr_set", 16'(ovrun), 16'h0020);
    ovr_clr = 1'b1; tick();
    chk("ovr_setwins", 16'(ovrun), 16'h0020);
    src = 8'h08; ovr_clr = 1'b1; tick();
    chk("ovr_clr", 16'(ovrun), 16'h0);
    chk("ovr_pend_kept", 16'(Dr), 16'h00DF);

    // level channel and priority
    wr(8'h88);
    chk("wr_clears5", 16'(Dr), 16'h00FF);
    src = 8'h00; tick();
    chk("lvl_irq", 16'(irq), 16'h1);
    chk("lvl_id", 16'(irq_id), 16'h3);
    src = 8'h80; tick(); src = 8'h00;
    chk("pri_id", 16'(irq_id), 16'h7);
    chk("pri_dr", 16'(Dr), 16'h0077);
    src = 8'h08; tick();
    chk("lvl_rel_dr", 16'(Dr), 16'h007F);
    chk("lvl_rel_id", 16'(irq_id), 16'h7);
    src = 8'h88; wr(8'h00); src = 8'h08;
    chk("wr0_wins", 16'(Dr), 16'h00FF);
    src = 8'h00; tick(); src = 8'h08;
    chk("lvl_masked", 16'(irq), 16'h0);

    // async reset mid-operation
    wr(8'hC1);
    src = 8'hC1; tick();
    src = 8'h48; tick();
    src = 8'h08; wr(8'h81);
    chk("pre_rst_dr", 16'(Dr), 16'h007E);
    chk("pre_rst_ovr", 16'(ovrun), 16'h0040);
    chk("pre_rst_id", 16'(irq_id), 16'h7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_irq", 16'(irq), 16'h0);
    chk("arst_dr", 16'(Dr), 16'h00FF);
    chk("arst_id", 16'(irq_id), 16'h0);
    chk("arst_ovr", 16'(ovrun), 16'h0);
    #2 reset_n = 1'b1;
    src = 8'h09; tick(); src = 8'h08;
    chk("rst_irqen", 16'(irq), 16'h0);

    // edge-mode channel 0
    wr_e = 1'b1; dw_e = 8'h01; tick();
    src_e = 8'h09; tick();
    chk("edge_latch", 16'(dr_e), 16'h00FE);
    tick(); tick(); tick();
    chk("edge_once", 16'(dr_e), 16'h00FE);
    wr_e = 1'b1; dw_e = 8'h00; tick();
    chk("edge_clr", 16'(dr_e), 16'h00FF);
    wr_e = 1'b1; dw_e = 8'h01; tick();
    tick();
    chk("edge_noretrig", 16'(irq_e), 16'h0);
    src_e = 8'h08; tick();
    src_e = 8'h09; tick();
    chk("edge_retrig", 16'(dr_e), 16'h00FE);
    chk("edge_id", 16'(id_e), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
